// File: rtl/pipe_ex.sv
// Execute stage: ALU, branch/jump resolution and address generation behind a
// one-entry valid/ready output register, with epoch-based squashing of wrong-path work.
module pipe_ex #(
  parameter int REG_SZ  = 32,
  parameter int ALUOP_L = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_L-1:0] in_alu_op,
  input  logic               in_alu_c,
  input  logic [4:0]         in_rd,
  input  logic [31:0]        in_pc,
  input  logic [REG_SZ-1:0]  in_opr1,
  input  logic [REG_SZ-1:0]  in_opr2,
  input  logic [REG_SZ-1:0]  in_val,
  input  logic               in_jp_e,
  input  logic               in_br_e,
  input  logic               in_wb_e,
  input  logic [1:0]         in_rw_e,
  input  logic [1:0]         in_rw_len,
  input  logic               in_epoch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_SZ-1:0]  out_res,
  output logic [REG_SZ-1:0]  out_val,
  output logic [4:0]         out_rd,
  output logic               out_wb_e,
  output logic [1:0]         out_rw_e,
  output logic [1:0]         out_rw_len,
  output logic [31:0]        out_pc,
  output logic [4:0]         EX_fwd_idx,
  output logic [31:0]        EX_fwd_val,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               epoch
);

  localparam logic [ALUOP_L-1:0] ALU_ADD  = ALUOP_L'(0);
  localparam logic [ALUOP_L-1:0] ALU_SUB  = ALUOP_L'(1);
  localparam logic [ALUOP_L-1:0] ALU_SLL  = ALUOP_L'(2);
  localparam logic [ALUOP_L-1:0] ALU_SRL  = ALUOP_L'(3);
  localparam logic [ALUOP_L-1:0] ALU_SRA  = ALUOP_L'(4);
  localparam logic [ALUOP_L-1:0] ALU_XOR  = ALUOP_L'(5);
  localparam logic [ALUOP_L-1:0] ALU_OR   = ALUOP_L'(6);
  localparam logic [ALUOP_L-1:0] ALU_AND  = ALUOP_L'(7);
  localparam logic [ALUOP_L-1:0] ALU_SLT  = ALUOP_L'(8);
  localparam logic [ALUOP_L-1:0] ALU_SLTU = ALUOP_L'(9);
  localparam logic [ALUOP_L-1:0] ALU_SEQ  = ALUOP_L'(10);
  localparam logic [ALUOP_L-1:0] ALU_PASS = ALUOP_L'(11);

  typedef struct packed {
    logic              valid;
    logic [REG_SZ-1:0] res;
    logic [REG_SZ-1:0] val;
    logic [4:0]        rd;
    logic              wb_e;
    logic [1:0]        rw_e;
    logic [1:0]        rw_len;
    logic [31:0]       pc;
  } out_reg_t;

  out_reg_t          out_q, out_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              epoch_q, epoch_d;

  logic              accept;
  logic [4:0]        shamt;
  logic [REG_SZ-1:0] alu_res;
  logic [REG_SZ-1:0] opr_sum;
  logic [31:0]       pc_plus_val;
  logic [31:0]       jump_target;

  assign in_ready    = !out_q.valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign shamt       = in_opr2[4:0];
  assign opr_sum     = in_opr1 + in_opr2;
  assign pc_plus_val = in_pc + 32'(in_val);
  assign jump_target = 32'(opr_sum) & ~32'd1;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path
    // can leave it unassigned and infer a latch.
    alu_res = '0;
    unique case (in_alu_op)
      ALU_ADD:  alu_res = opr_sum;
      ALU_SUB:  alu_res = in_opr1 - in_opr2;
      ALU_SLL:  alu_res = in_opr1 << shamt;
      ALU_SRL:  alu_res = in_opr1 >> shamt;
      ALU_SRA:  alu_res = REG_SZ'($signed(in_opr1) >>> shamt);
      ALU_XOR:  alu_res = in_opr1 ^ in_opr2;
      ALU_OR:   alu_res = in_opr1 | in_opr2;
      ALU_AND:  alu_res = in_opr1 & in_opr2;
      ALU_SLT:  alu_res = REG_SZ'(($signed(in_opr1) < $signed(in_opr2)) ^ in_alu_c);
      ALU_SLTU: alu_res = REG_SZ'((in_opr1 < in_opr2) ^ in_alu_c);
      ALU_SEQ:  alu_res = REG_SZ'((in_opr1 == in_opr2) ^ in_alu_c);
      ALU_PASS: alu_res = in_opr1;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    out_d            = out_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    epoch_d          = epoch_q;
    if (accept) begin
      if (in_epoch != epoch_q) begin
        out_d.valid = 1'b0;
      end else begin
        out_d.valid  = 1'b1;
        out_d.res    = alu_res;
        out_d.val    = in_val;
        out_d.rd     = in_rd;
        out_d.wb_e   = in_wb_e;
        out_d.rw_e   = in_rw_e;
        out_d.rw_len = in_rw_len;
        out_d.pc     = in_pc;
        if (in_jp_e) begin
          out_d.res        = REG_SZ'(pc_plus_val);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = jump_target;
          epoch_d          = ~epoch_q;
        end else if (in_br_e) begin
          out_d.wb_e = 1'b0;
          if (alu_res[0]) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = pc_plus_val;
            epoch_d          = ~epoch_q;
          end
        end else if (in_rw_e != 2'd0) begin
          out_d.res = opr_sum;
        end
      end
    end else if (out_ready) begin
      out_d.valid = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      epoch_q          <= 1'b0;
    end else begin
      out_q            <= out_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      epoch_q          <= epoch_d;
    end
  end

  assign out_valid      = out_q.valid;
  assign out_res        = out_q.res;
  assign out_val        = out_q.val;
  assign out_rd         = out_q.rd;
  assign out_wb_e       = out_q.wb_e;
  assign out_rw_e       = out_q.rw_e;
  assign out_rw_len     = out_q.rw_len;
  assign out_pc         = out_q.pc;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign epoch          = epoch_q;

  // Loads have no result yet, so only ALU/jump writebacks are forwarded.
  assign EX_fwd_idx = (out_q.valid && out_q.wb_e && out_q.rw_e == 2'd0) ? out_q.rd : 5'd0;
  assign EX_fwd_val = 32'(out_q.res);

endmodule

// File: tb/tb_pipe_ex.sv
// Directed bench for pipe_ex: ALU ops, branch/jump redirect, epoch squash,
// backpressure, load/store address path and mid-operation reset.
module tb_pipe_ex;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_SLL = 5'd2,  OP_SRL  = 5'd3;
  localparam logic [4:0] OP_SRA = 5'd4,  OP_XOR  = 5'd5,  OP_OR  = 5'd6,  OP_AND  = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9,  OP_SEQ = 5'd10, OP_PASS = 5'd11;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_alu_op;
  logic        in_alu_c;
  logic [4:0]  in_rd;
  logic [31:0] in_pc, in_opr1, in_opr2, in_val;
  logic        in_jp_e, in_br_e, in_wb_e;
  logic [1:0]  in_rw_e, in_rw_len;
  logic        in_epoch;
  logic        out_valid, out_ready;
  logic [31:0] out_res, out_val;
  logic [4:0]  out_rd;
  logic        out_wb_e;
  logic [1:0]  out_rw_e, out_rw_len;
  logic [31:0] out_pc;
  logic [4:0]  EX_fwd_idx;
  logic [31:0] EX_fwd_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        epoch;

  int checks = 0;
  int errors = 0;

  pipe_ex #(.REG_SZ(32), .ALUOP_L(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_alu_c(in_alu_c), .in_rd(in_rd), .in_pc(in_pc),
    .in_opr1(in_opr1), .in_opr2(in_opr2), .in_val(in_val),
    .in_jp_e(in_jp_e), .in_br_e(in_br_e), .in_wb_e(in_wb_e),
    .in_rw_e(in_rw_e), .in_rw_len(in_rw_len), .in_epoch(in_epoch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_val(out_val), .out_rd(out_rd), .out_wb_e(out_wb_e),
    .out_rw_e(out_rw_e), .out_rw_len(out_rw_len), .out_pc(out_pc),
    .EX_fwd_idx(EX_fwd_idx), .EX_fwd_val(EX_fwd_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .epoch(epoch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t alu_vecs [14] = '{
    '{OP_SUB,  1'b0, 32'd10,         32'd3,          32'd7},
    '{OP_SLL,  1'b0, 32'd1,          32'h24,         32'h10},
    '{OP_SRL,  1'b0, 32'h8000_0000,  32'd31,         32'd1},
    '{OP_SRA,  1'b0, 32'h8000_0000,  32'd4,          32'hF800_0000},
    '{OP_XOR,  1'b0, 32'hF0,         32'hFF,         32'h0F},
    '{OP_OR,   1'b0, 32'hF0,         32'h0F,         32'hFF},
    '{OP_AND,  1'b0, 32'hF0,         32'h3C,         32'h30},
    '{OP_SLT,  1'b0, 32'hFFFF_FFFF,  32'd0,          32'd1},
    '{OP_SLTU, 1'b0, 32'hFFFF_FFFF,  32'd0,          32'd0},
    '{OP_SLT,  1'b1, 32'hFFFF_FFFF,  32'd0,          32'd0},
    '{OP_SEQ,  1'b0, 32'd7,          32'd7,          32'd1},
    '{OP_PASS, 1'b0, 32'hDEAD,       32'h1234,       32'hDEAD},
    '{5'd31,   1'b0, 32'h1234,       32'h5678,       32'd0},
    '{OP_ADD,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0}
  };

  task automatic drive(input logic [4:0] op, input logic c, input logic [31:0] a, b, v, pc,
                       input logic [4:0] rd, input logic wb, jp, br,
                       input logic [1:0] rw, len, input logic ep);
    in_valid = 1'b1; in_alu_op = op; in_alu_c = c; in_opr1 = a; in_opr2 = b;
    in_val = v; in_pc = pc; in_rd = rd; in_wb_e = wb; in_jp_e = jp; in_br_e = br;
    in_rw_e = rw; in_rw_len = len; in_epoch = ep;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(OP_ADD, 1'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect_valid); end
    checks++; if (epoch !== 1'b0) begin errors++; $display("FAIL reset_epoch: got %b want 0", epoch); end
    checks++; if (out_res !== 32'd0 || out_pc !== 32'd0) begin errors++; $display("FAIL reset_data: res %h pc %h want 0", out_res, out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_add;
    drive(OP_ADD, 1'b0, 32'd5, 32'hFFFF_FFF9, 32'h11, 32'h40, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (out_res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_res: got %h want fffffffe", out_res); end
    checks++; if (EX_fwd_idx !== 5'd5 || EX_fwd_val !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_fwd: idx %0d val %h want 5 fffffffe", EX_fwd_idx, EX_fwd_val); end
    checks++; if (out_pc !== 32'h40 || out_val !== 32'h11 || out_rd !== 5'd5) begin errors++; $display("FAIL add_pass: pc %h val %h rd %0d", out_pc, out_val, out_rd); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL add_redirect: got %b want 0", redirect_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || EX_fwd_idx !== 5'd0) begin errors++; $display("FAIL add_drain: valid %b idx %0d want 0 0", out_valid, EX_fwd_idx); end
  endtask

  task automatic test_back_to_back_alu;
    for (int i = 0; i < 14; i++) begin
      drive(alu_vecs[i].op, alu_vecs[i].c, alu_vecs[i].a, alu_vecs[i].b, 32'd0, 32'h1000 + 32'(4 * i),
            5'(i + 1), 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_res !== alu_vecs[i].exp || EX_fwd_idx !== 5'(i + 1))
        begin errors++; $display("FAIL alu_vec%0d: valid %b res %h idx %0d want 1 %h %0d", i, out_valid, out_res, EX_fwd_idx, alu_vecs[i].exp, i + 1); end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bne;
    drive(OP_SEQ, 1'b1, 32'd3, 32'd3, 32'h20, 32'h80, 5'd9, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res[0] !== 1'b0) begin errors++; $display("FAIL bne_res: valid %b res %h want 1 bit0=0", out_valid, out_res); end
    checks++; if (out_wb_e !== 1'b0 || EX_fwd_idx !== 5'd0) begin errors++; $display("FAIL bne_wb: wb %b idx %0d want 0 0", out_wb_e, EX_fwd_idx); end
    checks++; if (redirect_valid !== 1'b0 || epoch !== 1'b0) begin errors++; $display("FAIL bne_redirect: rv %b epoch %b want 0 0", redirect_valid, epoch); end
    @(negedge clk);
  endtask

  task automatic test_load_store_fwd;
    drive(OP_PASS, 1'b0, 32'h1000, 32'h24, 32'hCAFE, 32'h90, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);
    @(negedge clk);
    checks++; if (out_res !== 32'h1024 || out_val !== 32'hCAFE) begin errors++; $display("FAIL store_addr: res %h val %h want 1024 cafe", out_res, out_val); end
    checks++; if (out_rw_e !== 2'd2 || out_rw_len !== 2'd2 || EX_fwd_idx !== 5'd0) begin errors++; $display("FAIL store_ctl: rw %0d len %0d idx %0d", out_rw_e, out_rw_len, EX_fwd_idx); end
    drive(OP_PASS, 1'b0, 32'h2000, 32'h8, 32'h0, 32'h94, 5'd7, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0);
    @(negedge clk);
    checks++; if (out_res !== 32'h2008 || EX_fwd_idx !== 5'd0 || out_wb_e !== 1'b1) begin errors++; $display("FAIL load_fwd: res %h idx %0d wb %b want 2008 0 1", out_res, EX_fwd_idx, out_wb_e); end
    drive(OP_ADD, 1'b0, 32'd1, 32'd2, 32'h0, 32'h98, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd3 || EX_fwd_idx !== 5'd0) begin errors++; $display("FAIL rd0_fwd: valid %b res %h idx %0d want 1 3 0", out_valid, out_res, EX_fwd_idx); end
    @(negedge clk);
  endtask

  task automatic test_jalr;
    drive(OP_ADD, 1'b0, 32'h203, 32'h0, 32'd4, 32'h100, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_res !== 32'h104 || EX_fwd_idx !== 5'd1) begin errors++; $display("FAIL jalr_link: res %h idx %0d want 104 1", out_res, EX_fwd_idx); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202) begin errors++; $display("FAIL jalr_redirect: rv %b pc %h want 1 202", redirect_valid, redirect_pc); end
    checks++; if (epoch !== 1'b1) begin errors++; $display("FAIL jalr_epoch: got %b want 1", epoch); end
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0 || epoch !== 1'b1) begin errors++; $display("FAIL jalr_pulse: rv %b epoch %b want 0 1", redirect_valid, epoch); end
  endtask

  task automatic test_stale;
    drive(OP_ADD, 1'b0, 32'h500, 32'h0, 32'd4, 32'h300, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || EX_fwd_idx !== 5'd0) begin errors++; $display("FAIL stale_drop: valid %b idx %0d want 0 0", out_valid, EX_fwd_idx); end
    checks++; if (redirect_valid !== 1'b0 || epoch !== 1'b1) begin errors++; $display("FAIL stale_redirect: rv %b epoch %b want 0 1", redirect_valid, epoch); end
    drive(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'h304, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd2 || EX_fwd_idx !== 5'd3) begin errors++; $display("FAIL stale_resume: valid %b res %h idx %0d want 1 2 3", out_valid, out_res, EX_fwd_idx); end
  endtask

  task automatic test_backpressure;
    drive(OP_ADD, 1'b0, 32'd2, 32'd3, 32'd0, 32'h400, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    checks++; if (out_res !== 32'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: res %h valid %b want 5 1", out_res, out_valid); end
    out_ready = 1'b0;
    drive(OP_ADD, 1'b0, 32'd10, 32'd10, 32'd0, 32'h404, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_res !== 32'd5 || out_rd !== 5'd4 || out_pc !== 32'h400 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: valid %b res %h rd %0d pc %h ready %b", i, out_valid, out_res, out_rd, out_pc, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd20 || out_rd !== 5'd6) begin errors++; $display("FAIL bp_resume: valid %b res %h rd %0d want 1 14 6", out_valid, out_res, out_rd); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    drive(OP_ADD, 1'b0, 32'h300, 32'h0, 32'd4, 32'h200, 5'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL mr_setup: valid %b rv %b want 1 1", out_valid, redirect_valid); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || epoch !== 1'b0) begin errors++; $display("FAIL mr_ctl: valid %b rv %b epoch %b want 0 0 0", out_valid, redirect_valid, epoch); end
    checks++; if (out_res !== 32'd0 || out_rd !== 5'd0 || out_pc !== 32'd0 || redirect_pc !== 32'd0 || EX_fwd_idx !== 5'd0)
      begin errors++; $display("FAIL mr_data: res %h rd %0d pc %h rpc %h idx %0d want 0", out_res, out_rd, out_pc, redirect_pc, EX_fwd_idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_no_pulse: rv %b valid %b want 0 0", redirect_valid, out_valid); end
    drive(OP_ADD, 1'b0, 32'd8, 32'd9, 32'd0, 32'h10, 5'd8, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd17) begin errors++; $display("FAIL mr_resume: valid %b res %h want 1 11", out_valid, out_res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back_alu();
    test_bne();
    test_load_store_fwd();
    test_jalr();
    test_stale();
    test_backpressure();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ex.md
PIPE_EX -- requirements
Module: pipe_ex

Interface
REQ-001 SHALL have parameter REG_SZ, default 32, the datapath and register width.
REQ-002 SHALL have parameter ALUOP_L, default 5, the ALU opcode width, with encodings per alu_opcode.v.
REQ-003 SHALL have ports `clk` (in, 1, the single clock) and `rst` (in, 1, reset); reset is asynchronous and active-low.
REQ-004 SHALL have input handshake ports `in_valid` (in, 1) and `in_ready` (out, 1).
REQ-005 SHALL have `in_alu_op` (in, ALUOP_L), `in_alu_c` (in, 1, invert compare result), `in_rd` (in, 5) and `in_pc` (in, 32).
REQ-006 SHALL have `in_opr1`, `in_opr2` and `in_val` (in, REG_SZ each, ALU operands and auxiliary value).
REQ-007 SHALL have `in_jp_e`, `in_br_e`, `in_wb_e` (in, 1 each), `in_rw_e` and `in_rw_len` (in, 2 each), and `in_epoch` (in, 1).
REQ-008 SHALL have output handshake ports `out_valid` (out, 1) and `out_ready` (in, 1).
REQ-009 SHALL have `out_res` and `out_val` (out, REG_SZ), `out_rd` (out, 5), `out_wb_e` (out, 1), `out_rw_e` and `out_rw_len` (out, 2), and `out_pc` (out, 32).
REQ-010 SHALL have `EX_fwd_idx` (out, 5) and `EX_fwd_val` (out, 32), the forwarding path to decode.
REQ-011 SHALL have `redirect_valid` (out, 1), `redirect_pc` (out, 32) and `epoch` (out, 1, the current epoch).

Function
REQ-012 SHALL drive `in_ready` = !out_valid || out_ready, combinationally.
REQ-013 SHALL treat a cycle with in_valid && in_ready as an accept.
- The output register loads the result at the next clock edge, giving 1-cycle latency.
REQ-014 SHALL discard an accepted input whose in_epoch != epoch: out_valid becomes 0, no redirect, no forward.
REQ-015 SHALL, with no accept and out_ready high, clear out_valid; with no accept and out_ready low, hold all outputs stable.
REQ-016 SHALL compute the ALU result as follows:
- ADD/SUB: modulo 2^REG_SZ.
- SLL/SRL/SRA: shift amount = opr2[4:0].
- XOR/OR/AND: bitwise.
- SLT (signed), SLTU, SEQ: 1/0, with bit0 XORed with in_alu_c.
- PASS: opr1.
- Undefined opcode: 0.
REQ-017 SHALL, for non-branch, non-jump ops, set out_res = ALU result and pass through val, rd, wb_e, rw_e, rw_len and pc.
REQ-018 SHALL, for in_jp_e, set out_res = in_pc + in_val (the link address) and target = (opr1 + opr2) & ~1.
REQ-019 SHALL, for in_br_e, take the branch iff bit0 of the compare result is 1; target = in_pc + in_val; out_wb_e = 0.
REQ-020 SHALL, on a matching-epoch accept of a jump or taken branch, do the following in the next cycle:
- pulse redirect_valid for exactly 1 cycle;
- drive redirect_pc = target;
- toggle epoch.
REQ-021 SHALL keep redirect_valid low for not-taken branches and for discarded inputs.
REQ-022 SHALL drive EX_fwd_idx = out_rd and EX_fwd_val = out_res when out_valid && out_wb_e && out_rw_e==0, and EX_fwd_idx = 0 otherwise.
REQ-023 SHALL force EX_fwd_idx = 0 when out_rd == 0.
REQ-024 SHALL, for loads/stores (rw_e != 0), set out_res = effective address opr1 + opr2 and out_val = in_val (the store data).
REQ-025 SHALL, when a redirect and a new accept share a cycle, compare the accepted instruction against the pre-toggle epoch.

Reset
REQ-026 SHALL, while rst is low, asynchronously force out_valid=0, redirect_valid=0, epoch=0 and all data outputs to 0.
REQ-027 SHALL, while rst is low, force in_ready=1.
REQ-028 SHALL, on reset mid-operation, drop any held output and any pending redirect with no pulse.
REQ-029 SHALL resume accepting inputs on the first clock edge after rst rises.

Verification
REQ-030 ADD test: opr1=5, opr2=-7, out_ready=1 -> next cycle out_valid=1, out_res=0xFFFFFFFE, EX_fwd_idx=rd.
REQ-031 BNE not-taken test: opr1=opr2=3, alu_c=1 -> out_res bit0=0, no redirect, out_wb_e=0.
REQ-032 JALR test: pc=0x100, opr1=0x203, opr2=0, val=4 -> out_res=0x104, redirect_pc=0x202, 1-cycle pulse, epoch 0->1.
REQ-033 Stale-instruction test: accept with in_epoch=0 after the toggle -> out_valid=0, EX_fwd_idx=0, no redirect.
REQ-034 Backpressure test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; accept resumes when out_ready=1.
REQ-035 Mid-operation reset test: rst low while out_valid=1 and a redirect is pending -> all outputs 0 immediately, in_ready=1.
